// File: rtl/ram_param.sv
// rtl/ram_param.sv - parametrised data RAM with registered read port and post-reset clear sequencer
module ram_param #(
  parameter int WIDTH          = 16,
  parameter int ADDR_W         = 12,
  parameter bit RDW_MODE       = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ld,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              clearing;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  assign clearing = (state == S_CLEAR);
  assign busy     = clearing;

  // The clear sequencer owns the single write port while busy; no write on a reset edge.
  always_comb begin
    we    = 1'b0;
    waddr = addr;
    wdata = in;
    if (rst_n) begin
      if (clearing) begin
        we    = 1'b1;
        waddr = clr_ptr;
        wdata = '0;
      end else begin
        we = ld;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      clr_ptr   <= '0;
      state     <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
    end else if (clearing) begin
      out_valid <= 1'b0;
      clr_ptr   <= clr_ptr + 1'b1;
      if (clr_ptr == '1) state <= S_READY;
    end else begin
      out_valid <= rd_en;
      // Write-first forwards the incoming word; read-first sees the array before this edge.
      if (rd_en) out <= (RDW_MODE && ld) ? in : mem[addr];
    end
  end

endmodule

// File: tb/tb_ram_param.sv
// tb/tb_ram_param.sv - randomized and directed checks of ram_param against an array reference model
module tb_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_rst_n, a_ld, a_rd, a_valid, a_busy;
  logic [15:0] a_in, a_out;
  logic [11:0] a_addr;

  logic        b_rst_n, b_ld, b_rd, b_valid, b_busy;
  logic [7:0]  b_in, b_out;
  logic [3:0]  b_addr;

  logic        c_rst_n, c_ld, c_rd, c_valid, c_busy;
  logic [15:0] c_in, c_out;
  logic [3:0]  c_addr;

  ram_param u_a (
    .clk(clk), .rst_n(a_rst_n), .in(a_in), .addr(a_addr), .ld(a_ld), .rd_en(a_rd),
    .out(a_out), .out_valid(a_valid), .busy(a_busy)
  );

  ram_param #(.WIDTH(8), .ADDR_W(4), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in(b_in), .addr(b_addr), .ld(b_ld), .rd_en(b_rd),
    .out(b_out), .out_valid(b_valid), .busy(b_busy)
  );

  ram_param #(.WIDTH(16), .ADDR_W(4), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b0)) u_c (
    .clk(clk), .rst_n(c_rst_n), .in(c_in), .addr(c_addr), .ld(c_ld), .rd_en(c_rd),
    .out(c_out), .out_valid(c_valid), .busy(c_busy)
  );

  logic [15:0] model_a [4096];
  logic [7:0]  model_b [16];
  logic [15:0] model_c [16];
  logic [15:0] held [3];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input bit rst_n, input bit ld, input bit rd,
                       input int addr, input logic [15:0] d);
    case (u)
      0: begin a_rst_n = rst_n; a_ld = ld; a_rd = rd; a_addr = addr[11:0]; a_in = d; end
      1: begin b_rst_n = rst_n; b_ld = ld; b_rd = rd; b_addr = addr[3:0]; b_in = d[7:0]; end
      default: begin c_rst_n = rst_n; c_ld = ld; c_rd = rd; c_addr = addr[3:0]; c_in = d; end
    endcase
  endtask

  function automatic logic [15:0] dut_out(input int u);
    case (u)
      0:       return a_out;
      1:       return {8'h00, b_out};
      default: return c_out;
    endcase
  endfunction

  function automatic logic dut_valid(input int u);
    case (u)
      0:       return a_valid;
      1:       return b_valid;
      default: return c_valid;
    endcase
  endfunction

  function automatic logic dut_busy(input int u);
    case (u)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic [15:0] model_rd(input int u, input int addr);
    case (u)
      0:       return model_a[addr[11:0]];
      1:       return {8'h00, model_b[addr[3:0]]};
      default: return model_c[addr[3:0]];
    endcase
  endfunction

  task automatic model_wr(input int u, input int addr, input logic [15:0] d);
    case (u)
      0:       model_a[addr[11:0]] = d;
      1:       model_b[addr[3:0]]  = d[7:0];
      default: model_c[addr[3:0]]  = d;
    endcase
  endtask

  // One READY-state access: the model decides what the read sees, then the array is updated.
  task automatic op(input int u, input bit ld, input bit rd, input int addr,
                    input logic [15:0] d, input string tag);
    logic [15:0] dm;
    logic [15:0] exp;
    dm  = (u == 1) ? (d & 16'h00ff) : d;
    exp = held[u];
    if (rd) exp = (ld && u == 1) ? dm : model_rd(u, addr);
    drive(u, 1'b1, ld, rd, addr, dm);
    tick();
    if (ld) model_wr(u, addr, dm);
    held[u] = exp;
    chk({tag, "_out"}, dut_out(u), exp);
    chk({tag, "_valid"}, {15'b0, dut_valid(u)}, {15'b0, rd});
    drive(u, 1'b1, 1'b0, 1'b0, addr, dm);
  endtask

  task automatic count_busy(input int u, output int n);
    n = 0;
    while (dut_busy(u) && n < 20000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int  n;
    bit  lock_bad;

    drive(0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    drive(2, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    for (int i = 0; i < 3; i++) held[i] = 16'h0;

    // Default instance: reset, lockout during clear, mid-clear reset, full clear length.
    tick();
    tick();
    chk("a_rst_out", a_out, 16'h0);
    chk("a_rst_valid", {15'b0, a_valid}, 16'h0);
    chk("a_rst_busy", {15'b0, a_busy}, 16'h1);

    drive(0, 1'b1, 1'b1, 1'b1, 10, 16'hFFFF);
    lock_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (a_valid !== 1'b0 || a_out !== 16'h0 || a_busy !== 1'b1) lock_bad = 1'b1;
    end
    chk("a_lockout", {15'b0, lock_bad}, 16'h0);

    drive(0, 1'b0, 1'b1, 1'b1, 10, 16'hFFFF);
    tick();
    chk("a_midrst_busy", {15'b0, a_busy}, 16'h1);
    drive(0, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    count_busy(0, n);
    chk("a_busy_len", n[15:0], 16'd4096);
    for (int i = 0; i < 4096; i++) model_a[i] = 16'h0;

    op(0, 1'b0, 1'b1, 0,    16'h0, "a_rd0");
    op(0, 1'b0, 1'b1, 2047, 16'h0, "a_rd2047");
    op(0, 1'b0, 1'b1, 4095, 16'h0, "a_rd4095");
    op(0, 1'b0, 1'b1, 10,   16'h0, "a_rd10");
    chk("a_rd10_zero", a_out, 16'h0000);

    op(0, 1'b1, 1'b0, 'h123, 16'hBEEF, "a_wr123");
    op(0, 1'b0, 1'b1, 'h123, 16'h0,    "a_rd123");
    chk("a_rd123_const", a_out, 16'hBEEF);
    op(0, 1'b0, 1'b0, 'h000, 16'h0,    "a_hold");
    chk("a_hold_const", a_out, 16'hBEEF);
    op(0, 1'b0, 1'b1, 'h124, 16'h0,    "a_rd124");

    op(0, 1'b1, 1'b0, 5, 16'h1111, "a_pre5");
    op(0, 1'b1, 1'b1, 5, 16'h2222, "a_rdw5");
    chk("a_rdw_old", a_out, 16'h1111);
    op(0, 1'b0, 1'b1, 5, 16'h0,    "a_after5");
    chk("a_after5_const", a_out, 16'h2222);

    for (int i = 0; i < 400; i++)
      op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         'h200 + int'($urandom_range(0, 15)), 16'($urandom), "a_rnd");

    // Narrow write-first instance.
    drive(1, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    tick();
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    count_busy(1, n);
    chk("b_busy_len", n[15:0], 16'd16);
    for (int i = 0; i < 16; i++) model_b[i] = 8'h0;
    held[1] = 16'h0;

    op(1, 1'b1, 1'b0, 15, 16'h00A5, "b_wr15");
    op(1, 1'b0, 1'b1, 15, 16'h0,    "b_rd15");
    chk("b_rd15_const", {8'h00, b_out}, 16'h00A5);
    op(1, 1'b0, 1'b1, 0,  16'h0,    "b_rd0");
    op(1, 1'b1, 1'b0, 5,  16'h0011, "b_pre5");
    op(1, 1'b1, 1'b1, 5,  16'h0022, "b_rdw5");
    chk("b_rdw_new", {8'h00, b_out}, 16'h0022);
    op(1, 1'b0, 1'b1, 5,  16'h0,    "b_after5");

    for (int i = 0; i < 200; i++)
      op(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 15)), 16'($urandom), "b_rnd");

    // No-clear instance: contents survive reset.
    drive(2, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    tick();
    tick();
    drive(2, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    tick();
    chk("c_busy_idle", {15'b0, c_busy}, 16'h0);
    chk("c_rst_out", c_out, 16'h0);
    held[2] = 16'h0;

    op(2, 1'b1, 1'b0, 7, 16'h00FF, "c_wr7");
    op(2, 1'b0, 1'b1, 7, 16'h0,    "c_rd7");
    op(2, 1'b1, 1'b0, 3, 16'hAAAA, "c_pre3");
    op(2, 1'b1, 1'b1, 3, 16'hBBBB, "c_rdw3");

    drive(2, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    tick();
    chk("c_pulse_busy", {15'b0, c_busy}, 16'h0);
    chk("c_pulse_out", c_out, 16'h0);
    chk("c_pulse_valid", {15'b0, c_valid}, 16'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    tick();
    chk("c_busy_after", {15'b0, c_busy}, 16'h0);
    held[2] = 16'h0;
    op(2, 1'b0, 1'b1, 7, 16'h0, "c_keep7");
    chk("c_keep7_const", c_out, 16'h00FF);
    op(2, 1'b0, 1'b1, 3, 16'h0, "c_keep3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
